// File: rtl/radix2_seq_divider.sv
// Restoring radix-2 sequential divider, one quotient bit per clock.
// Handles unsigned or two's-complement operands and can round the quotient
// half away from zero. It flags divide-by-zero and the signed MIN/-1 overflow.
module radix2_seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             sign_mode,
  input  logic             round_mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t                  state, state_nxt;
  logic                    accept;
  logic [CNT_W-1:0]        cnt;

  // Operation context captured when a start is accepted
  logic [WIDTH-1:0]        dvd_raw;
  logic [WIDTH-1:0]        dvs_mag;
  logic                    neg_q, neg_r, rnd, dz, ovf;

  // Partial remainder {rem_q, acc_q}; acc_q fills with quotient bits from the right
  logic [WIDTH-1:0]        rem_q;
  logic [WIDTH-1:0]        acc_q;
  logic [WIDTH:0]          shifted;
  logic [WIDTH:0]          trial;
  logic                    keep;

  logic [WIDTH-1:0]        q_mag, q_fix, r_fix;

  // Two's-complement magnitude when operands are signed, identity otherwise
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  // Round-half-away-from-zero on magnitudes: bump |q| when 2*|r| >= |d|
  function automatic logic [WIDTH-1:0] round_up(input logic [WIDTH-1:0] qm,
                                                input logic [WIDTH-1:0] rm,
                                                input logic [WIDTH-1:0] dm,
                                                input logic             en);
    return (en && ({rm, 1'b0} >= {1'b0, dm})) ? qm + ONE : qm;
  endfunction

  // Apply the result sign in WIDTH-bit two's complement
  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign shifted = {rem_q, acc_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_mag};
  assign keep    = ~trial[WIDTH];

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and status outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        busy = 1'b1;
        if (cnt == '0) state_nxt = S_FIX;
      end
      S_FIX: begin
        busy      = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_CALC;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bit counter: WIDTH-1 down to 0 across the CALC phase
  always_ff @(posedge clk) begin
    if (!rst_n)              cnt <= '0;
    else if (accept)         cnt <= CNT_W'(WIDTH - 1);
    else if (state == S_CALC) cnt <= cnt - CNT_W'(1);
  end

  // Operand capture and one restoring step per CALC cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      dvd_raw <= dividend;
      dvs_mag <= magnitude(divisor, sign_mode);
      acc_q   <= magnitude(dividend, sign_mode);
      rem_q   <= '0;
      neg_q   <= sign_mode & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      neg_r   <= sign_mode & dividend[WIDTH-1];
      rnd     <= round_mode;
      dz      <= (divisor == '0);
      ovf     <= sign_mode && (dividend == MIN_VAL) && (divisor == '1);
    end else if (state == S_CALC) begin
      rem_q <= keep ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
      acc_q <= {acc_q[WIDTH-2:0], keep};
    end
  end

  // Final correction: rounding, sign restore, divide-by-zero override
  always_comb begin
    q_mag = round_up(acc_q, rem_q, dvs_mag, rnd);
    q_fix = apply_sign(q_mag, neg_q);
    r_fix = apply_sign(rem_q, neg_r);
    if (dz) begin
      q_fix = '1;
      r_fix = dvd_raw;
    end
  end

  // Result registers: change only on the FIX->DONE edge, held otherwise
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else if (state == S_FIX) begin
      quotient    <= q_fix;
      remainder   <= r_fix;
      div_by_zero <= dz;
      overflow    <= ovf;
    end
  end

endmodule

// File: tb/tb_radix2_seq_divider.sv
// Scoreboard bench for radix2_seq_divider: 32-bit and 8-bit instances.
module tb_radix2_seq_divider;

  localparam int W  = 32;
  localparam int W8 = 8;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    bit          dz;
    bit          ov;
    longint      cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // 32-bit DUT signals
  logic          rst_n, start, sign_mode, round_mode;
  logic [W-1:0]  dividend, divisor;
  logic          busy, done, div_by_zero, overflow;
  logic [W-1:0]  quotient, remainder;

  // 8-bit DUT signals
  logic          rst8_n, start8, sign8, round8;
  logic [W8-1:0] dividend8, divisor8;
  logic          busy8, done8, dz8, ov8;
  logic [W8-1:0] quotient8, remainder8;

  radix2_seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .sign_mode(sign_mode), .round_mode(round_mode), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero), .overflow(overflow)
  );

  radix2_seq_divider #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst_n(rst8_n), .start(start8), .dividend(dividend8), .divisor(divisor8),
    .sign_mode(sign8), .round_mode(round8), .busy(busy8), .done(done8),
    .quotient(quotient8), .remainder(remainder8), .div_by_zero(dz8), .overflow(ov8)
  );

  exp_t sb[$];
  exp_t sb8[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer division on magnitudes, signs applied afterwards
  function automatic exp_t model(input int w, input longint a, input longint b,
                                 input bit s, input bit rnd);
    exp_t   e;
    longint mask, half, sa, sb_, ma, mb, qm, rm;
    mask  = (longint'(1) << w) - 1;
    half  = longint'(1) << (w - 1);
    e.cyc = 0;
    e.dz  = (b == 0);
    e.ov  = s && (a == half) && (b == mask);
    if (e.dz) begin
      e.q = mask;
      e.r = a;
      return e;
    end
    sa  = (s && a >= half) ? a - (longint'(1) << w) : a;
    sb_ = (s && b >= half) ? b - (longint'(1) << w) : b;
    ma  = (sa < 0) ? -sa : sa;
    mb  = (sb_ < 0) ? -sb_ : sb_;
    qm  = ma / mb;
    rm  = ma % mb;
    if (rnd && (2 * rm >= mb)) qm++;
    e.q = (((sa < 0) != (sb_ < 0)) ? -qm : qm) & mask;
    e.r = ((sa < 0) ? -rm : rm) & mask;
    return e;
  endfunction

  // Present an operation and hold start until the DUT accepts it
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit s, input bit r);
    exp_t e;
    int   guard = 0;
    dividend = a; divisor = b; sign_mode = s; round_mode = r; start = 1'b1;
    while (busy !== 1'b0) begin
      @(negedge clk);
      guard++;
      if (guard > 4 * W) begin
        $display("FAIL busy_timeout: busy stuck at %b", busy);
        $fatal(1, "busy never dropped");
      end
    end
    @(posedge clk); #1;
    e     = model(W, longint'(a), longint'(b), s, r);
    e.cyc = cyc + W + 1;
    sb.push_back(e);
    start = 1'b0;
  endtask

  task automatic issue8(input logic [W8-1:0] a, input logic [W8-1:0] b, input bit s, input bit r);
    exp_t e;
    int   guard = 0;
    dividend8 = a; divisor8 = b; sign8 = s; round8 = r; start8 = 1'b1;
    while (busy8 !== 1'b0) begin
      @(negedge clk);
      guard++;
      if (guard > 4 * W8) begin
        $display("FAIL busy8_timeout: busy8 stuck at %b", busy8);
        $fatal(1, "busy8 never dropped");
      end
    end
    @(posedge clk); #1;
    e     = model(W8, longint'(a), longint'(b), s, r);
    e.cyc = cyc + W8 + 1;
    sb8.push_back(e);
    start8 = 1'b0;
  endtask

  task automatic drain(input bit wide);
    int guard = 0;
    while ((wide ? sb.size() : sb8.size()) != 0 && guard < 8 * W) begin
      @(negedge clk);
      guard++;
    end
    n_vec++;
    if ((wide ? sb.size() : sb8.size()) != 0) begin
      n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0",
               wide ? sb.size() : sb8.size());
    end
  endtask

  // Monitor for the 32-bit DUT: results at done, outputs held in between
  bit         hold_en = 1'b0;
  logic [W-1:0] last_q = '0, last_r = '0;
  int         done_cnt = 0;
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(done), 64'd0);
      end else begin
        e = sb.pop_front();
        check("quotient",    64'(quotient),    e.q);
        check("remainder",   64'(remainder),   e.r);
        check("div_by_zero", 64'(div_by_zero), 64'(e.dz));
        check("overflow",    64'(overflow),    64'(e.ov));
        check("done_cycle",  64'(cyc),         64'(e.cyc));
      end
      last_q = quotient;
      last_r = remainder;
    end else if (hold_en) begin
      check("hold_quotient",  64'(quotient),  64'(last_q));
      check("hold_remainder", 64'(remainder), 64'(last_r));
    end
  end

  // Monitor for the 8-bit DUT
  always @(negedge clk) begin
    exp_t e;
    if (done8 === 1'b1) begin
      if (sb8.size() == 0) begin
        check("w8_unexpected_done", 64'(done8), 64'd0);
      end else begin
        e = sb8.pop_front();
        check("w8_quotient",   64'(quotient8),  e.q);
        check("w8_remainder",  64'(remainder8), e.r);
        check("w8_div_by_zero", 64'(dz8),       64'(e.dz));
        check("w8_overflow",   64'(ov8),        64'(e.ov));
        check("w8_done_cycle", 64'(cyc),        64'(e.cyc));
      end
    end
  end

  function automatic logic [W-1:0] rand_dvd();
    case ($urandom_range(0, 7))
      0:       return 32'h8000_0000;
      1:       return $urandom_range(0, 100);
      default: return $urandom >> $urandom_range(0, 31);
    endcase
  endfunction

  function automatic logic [W-1:0] rand_dvs();
    case ($urandom_range(0, 15))
      0:          return '0;
      1:          return '1;
      2, 3, 4, 5: return $urandom_range(1, 20);
      default:    return $urandom >> $urandom_range(0, 31);
    endcase
  endfunction

  bit done8_flow = 1'b0;

  // 8-bit instance stimulus
  initial begin
    rst8_n = 1'b0; start8 = 1'b0; dividend8 = '0; divisor8 = '0; sign8 = 1'b0; round8 = 1'b0;
    repeat (3) @(negedge clk);
    rst8_n = 1'b1;
    issue8(8'd200, 8'd3, 1'b0, 1'b0);
    issue8(8'h80, 8'hFF, 1'b1, 1'b0);
    issue8(8'hF9, 8'h02, 1'b1, 1'b1);
    issue8(8'd77, 8'd0, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++)
      issue8(8'($urandom), 8'($urandom_range(0, 255) >> $urandom_range(0, 7)),
             1'($urandom), 1'($urandom));
    drain(1'b0);
    done8_flow = 1'b1;
  end

  // 32-bit instance stimulus
  initial begin
    int guard;
    int dc0;
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0; sign_mode = 1'b0; round_mode = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy",     64'(busy),        64'd0);
    check("reset_done",     64'(done),        64'd0);
    check("reset_quotient", 64'(quotient),    64'd0);
    check("reset_remainder", 64'(remainder),  64'd0);
    check("reset_flags",    64'({div_by_zero, overflow}), 64'd0);
    rst_n   = 1'b1;
    hold_en = 1'b1;

    // Directed cases
    issue(32'd100, 32'd7, 1'b0, 1'b0);
    issue(32'd100, 32'd8, 1'b0, 1'b1);
    issue(32'd100, 32'd7, 1'b0, 1'b1);
    issue(-32'sd7, 32'd2, 1'b1, 1'b0);
    issue(-32'sd7, 32'd2, 1'b1, 1'b1);
    issue(32'd7, -32'sd2, 1'b1, 1'b0);
    issue(32'd55, 32'd0, 1'b0, 1'b0);
    issue(32'd55, 32'd0, 1'b1, 1'b1);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    issue(32'd9, 32'd3, 1'b0, 1'b0);
    issue(32'd3, 32'd10, 1'b0, 1'b1);
    issue(-32'sd3, 32'd10, 1'b1, 1'b0);
    issue(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);

    // Start pulse with new operands during a busy operation must be ignored
    drain(1'b1);
    issue(32'd1000, 32'd33, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    dividend = 32'd12345; divisor = 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain(1'b1);

    // Randomised back-to-back and gapped traffic
    for (int i = 0; i < 150; i++) begin
      issue(rand_dvd(), rand_dvs(), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 40)) @(negedge clk);
    end
    drain(1'b1);

    // Reset during CALC: no result, outputs cleared
    issue(32'd5000, 32'd7, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    hold_en = 1'b0;
    rst_n   = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    @(negedge clk);
    check("midreset_busy",      64'(busy),      64'd0);
    check("midreset_quotient",  64'(quotient),  64'd0);
    check("midreset_remainder", 64'(remainder), 64'd0);
    check("midreset_flags",     64'({div_by_zero, overflow}), 64'd0);
    last_q  = '0;
    last_r  = '0;
    hold_en = 1'b1;
    dc0     = done_cnt;
    repeat (W + 6) @(negedge clk);
    check("midreset_no_done", 64'(done_cnt - dc0), 64'd0);

    // Operation after the aborted one completes normally
    issue(32'd200, 32'd3, 1'b0, 1'b0);
    drain(1'b1);

    guard = 0;
    while (!done8_flow && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    n_vec++;
    if (!done8_flow) begin
      n_err++;
      $display("FAIL w8_flow_timeout: finished=%0d, expected 1", done8_flow);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
